win_rr_arbiter: RTL and testbench
=================================

Name: win_rr_arbiter

Overview:
- Round-robin grant stage directly downstream of the 16-to-8 win-merge OR stage.
- Takes the merged 8-bit win/request vector, selects one winner fairly, and offers it on a valid/ready handshake.
- Holds the grant until the winner signals completion, then advances priority past the winner.
- Feeds the per-master transaction issue logic in the ACE interconnect.

Parameters:
- N, 8: number of requesters; must equal the merged vector width.
- IW, 3: winner index width, clog2(N).
- CW, 16: width of the saturating grant counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  N  merged win/request vector from the merge stage; bit i = requester i.
- grant_valid  output  1  grant offer is valid.
- grant_ready  input  1  consumer accepts the offered grant.
- grant_oh  output  N  one-hot winner; zero when no grant is offered or held.
- grant_idx  output  IW  binary index of the winner.
- busy  output  1  grant accepted, winner transaction in progress.
- done  input  1  single-cycle completion pulse for the current winner.
- grant_count  output  CW  number of accepted grants, saturating.

Behaviour:
- Reset (rst sampled high at a clock edge):
  - state=IDLE, ptr=0, grant_valid=0, grant_oh=0, grant_idx=0, busy=0, grant_count=0.
  - Reset wins over all other inputs, including mid-OFFER or mid-BUSY; no done is required afterwards.
- The state machine has three states: IDLE, OFFER, BUSY.
- IDLE:
  - If req_in != 0, the winner is the first set bit scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap-around).
  - The next edge registers grant_oh/grant_idx, sets grant_valid=1, and moves to OFFER.
  - Latency: req_in sampled at edge t gives grant_valid high after edge t; no combinational path from req_in to outputs.
  - If req_in == 0, stay in IDLE and keep all outputs at 0.
- OFFER:
  - grant_valid, grant_oh and grant_idx stay stable until accepted.
  - Changes to req_in, including withdrawal of the winner's bit, are ignored.
  - Acceptance is an edge where grant_valid=1 and grant_ready=1. On acceptance: grant_valid=0, busy=1, grant_count increments (held at 2^CW-1 once reached), move to BUSY.
  - grant_oh and grant_idx are held through BUSY.
  - done in OFFER is ignored, including when it arrives in the same cycle as acceptance.
- BUSY:
  - Wait for done. On done: ptr = (grant_idx+1) mod N, grant_oh=0, busy=0, move to IDLE.
  - Minimum re-arbitration: done at edge t, grant_valid again after edge t+1.
- Invariants:
  - grant_ready is don't-care outside OFFER.
  - grant_valid and busy are never both high.
  - grant_oh is always one-hot or zero.
  - grant_idx always matches grant_oh while either is non-zero.
- Priority pointer:
  - Changes only on done in BUSY, never on acceptance alone.
  - If winner is N-1, ptr wraps to 0.
- A single persistent requester is re-granted every cycle it wins; there are no starvation exceptions. With all bits set, winners cycle 0,1,...,7,0.

Test Plan:
- Reset then req_in=8'h00 for 10 cycles -> grant_valid=0, grant_oh=0, busy=0, grant_count=0 throughout.
- req_in=8'hFF held, grant_ready=1, done one cycle after each busy rise -> grant_idx sequence 0,1,2,3,4,5,6,7,0; grant_count=9.
- ptr=0, req_in=8'h90 -> grant_oh=8'h10 (idx 4); after done, req_in=8'h90 -> grant_oh=8'h80 (idx 7); after done -> idx 4 (wrap check).
- Offer held with grant_ready=0 for 5 cycles while req_in changes 8'h04->8'h00 -> grant_oh stays 8'h04, grant_valid stays 1.
- done pulsed during OFFER and same cycle as acceptance -> ignored; busy=1 until a later done; ptr unchanged until then.
- rst asserted mid-BUSY with grant_count=3 -> next cycle all outputs 0, ptr=0; req_in=8'h02 then grants idx 1.

Source files
------------

// File: rtl/win_rr_arbiter.sv
// win_rr_arbiter: round-robin grant stage after the 16-to-8 win-merge.
// Ports: clk/rst, req_in, grant_valid/ready/oh/idx, busy, done, grant_count.
module win_rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_in,
  output logic          grant_valid,
  input  logic          grant_ready,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          busy,
  input  logic          done,
  output logic [CW-1:0] grant_count
);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    BUSY
  } state_t;

  state_t        st_q;
  state_t        st_d;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [N-1:0]  oh_q;
  logic [N-1:0]  oh_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic          pick_hit;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] pos;
  logic [N-1:0]  one;

  assign one = {{(N-1){1'b0}}, 1'b1};

  // Scan ptr, ptr+1, ... with wrap; first set bit wins.
  always_comb begin
    pick_hit = 1'b0;
    pick_idx = '0;
    pos      = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr_q) + k) % N);
      if (!pick_hit && req_in[pos]) begin
        pick_hit = 1'b1;
        pick_idx = pos;
      end
    end
  end

  always_comb begin
    st_d  = st_q;
    ptr_d = ptr_q;
    oh_d  = oh_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    unique case (st_q)
      IDLE: begin
        if (pick_hit) begin
          st_d  = OFFER;
          oh_d  = one << pick_idx;
          idx_d = pick_idx;
        end
      end
      OFFER: begin
        // done is ignored here; only acceptance moves on.
        if (grant_ready) begin
          st_d = BUSY;
          if (!(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      BUSY: begin
        if (done) begin
          st_d  = IDLE;
          ptr_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
          oh_d  = '0;
          idx_d = '0;
        end
      end
      default: begin
        st_d  = IDLE;
        oh_d  = '0;
        idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      ptr_q <= '0;
      oh_q  <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      ptr_q <= ptr_d;
      oh_q  <= oh_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  // All outputs come straight from state; no path from req_in.
  assign grant_valid = (st_q == OFFER);
  assign busy        = (st_q == BUSY);
  assign grant_oh    = oh_q;
  assign grant_idx   = idx_q;
  assign grant_count = cnt_q;

endmodule

// File: tb/tb_win_rr_arbiter.sv
// tb_win_rr_arbiter: vector table, corner sequences and random traffic
// checked against a cycle-level reference model of the arbiter rules.
module tb_win_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_in = 8'h00;
  logic       grant_ready = 1'b0;
  logic       done = 1'b0;

  logic       grant_valid;
  logic [7:0] grant_oh;
  logic [2:0] grant_idx;
  logic       busy;
  logic [15:0] grant_count;

  logic       s_valid;
  logic [7:0] s_oh;
  logic [2:0] s_idx;
  logic       s_busy;
  logic [1:0] s_count;

  win_rr_arbiter #(.N(8), .IW(3), .CW(16)) dut (
    .clk(clk),
    .rst(rst),
    .req_in(req_in),
    .grant_valid(grant_valid),
    .grant_ready(grant_ready),
    .grant_oh(grant_oh),
    .grant_idx(grant_idx),
    .busy(busy),
    .done(done),
    .grant_count(grant_count)
  );

  // Narrow counter copy so saturation is reachable in a short run.
  win_rr_arbiter #(.N(8), .IW(3), .CW(2)) dut_sat (
    .clk(clk),
    .rst(rst),
    .req_in(req_in),
    .grant_valid(s_valid),
    .grant_ready(grant_ready),
    .grant_oh(s_oh),
    .grant_idx(s_idx),
    .busy(s_busy),
    .done(done),
    .grant_count(s_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: phase 0 idle, 1 offered, 2 in progress.
  int m_ph = 0;
  int m_ptr = 0;
  int m_win = 0;
  int m_acc = 0;

  task automatic model_step();
    bit hit;
    int j;
    if (rst) begin
      m_ph = 0;
      m_ptr = 0;
      m_win = 0;
      m_acc = 0;
    end else if (m_ph == 0) begin
      hit = 0;
      for (int k = 0; k < 8; k++) begin
        j = (m_ptr + k) % 8;
        if (!hit && req_in[j]) begin
          hit = 1;
          m_win = j;
        end
      end
      if (hit) m_ph = 1;
    end else if (m_ph == 1) begin
      if (grant_ready) begin
        m_ph = 2;
        m_acc++;
      end
    end else begin
      if (done) begin
        m_ph = 0;
        m_ptr = (m_win + 1) % 8;
      end
    end
  endtask

  task automatic cyc();
    int ecnt;
    int ecnt2;
    @(posedge clk);
    model_step();
    #1;
    ecnt = (m_acc > 65535) ? 65535 : m_acc;
    ecnt2 = (m_acc > 3) ? 3 : m_acc;
    chk("m_valid", grant_valid, m_ph == 1);
    chk("m_busy", busy, m_ph == 2);
    chk("m_oh", grant_oh, (m_ph == 0) ? 0 : (1 << m_win));
    chk("m_idx", grant_idx, (m_ph == 0) ? 0 : m_win);
    chk("m_count", grant_count, ecnt);
    chk("m_count_sat", s_count, ecnt2);
    chk("valid_busy_excl", grant_valid && busy, 0);
    chk("oh_onehot0", $countones(grant_oh) <= 1, 1);
  endtask

  typedef struct {
    bit       r;
    bit [7:0] req;
    bit       rdy;
    bit       dn;
    bit       ev;
    bit [7:0] eoh;
    bit [2:0] eidx;
    bit       eb;
    int       ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit [7:0] req, bit rdy, bit dn,
                              bit ev, bit [7:0] eoh, bit [2:0] eidx,
                              bit eb, int ecnt);
    vec_t v;
    v.r = r;
    v.req = req;
    v.rdy = rdy;
    v.dn = dn;
    v.ev = ev;
    v.eoh = eoh;
    v.eidx = eidx;
    v.eb = eb;
    v.ecnt = ecnt;
    tbl.push_back(v);
  endfunction

  // Offer, accept, then done: three edges for one full grant.
  function automatic void grant3(bit [7:0] req, int idx, int c);
    bit [7:0] oh;
    oh = 8'(1 << idx);
    add(0, req, 1, 0, 1, oh, 3'(idx), 0, c - 1);
    add(0, req, 1, 0, 0, oh, 3'(idx), 1, c);
    add(0, req, 1, 1, 0, 8'h00, 3'd0, 0, c);
  endfunction

  initial begin
    bit [31:0] r;

    add(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      add(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    for (int k = 0; k < 9; k++)
      grant3(8'hFF, k % 8, k + 1);

    add(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    grant3(8'h90, 4, 1);
    grant3(8'h90, 7, 2);
    grant3(8'h90, 4, 3);

    add(0, 8'h04, 0, 0, 1, 8'h04, 2, 0, 3);
    add(0, 8'h04, 0, 0, 1, 8'h04, 2, 0, 3);
    add(0, 8'h04, 0, 1, 1, 8'h04, 2, 0, 3);
    add(0, 8'h00, 0, 0, 1, 8'h04, 2, 0, 3);
    add(0, 8'h00, 0, 1, 1, 8'h04, 2, 0, 3);
    add(0, 8'h00, 0, 0, 1, 8'h04, 2, 0, 3);
    add(0, 8'h00, 1, 1, 0, 8'h04, 2, 1, 4);
    add(0, 8'h00, 1, 0, 0, 8'h04, 2, 1, 4);
    add(0, 8'hFF, 0, 0, 0, 8'h04, 2, 1, 4);
    add(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 4);
    grant3(8'hFF, 3, 5);

    add(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    grant3(8'hFF, 0, 1);
    grant3(8'hFF, 1, 2);
    add(0, 8'hFF, 1, 0, 1, 8'h04, 2, 0, 2);
    add(0, 8'hFF, 1, 0, 0, 8'h04, 2, 1, 3);
    add(1, 8'hFF, 1, 1, 0, 8'h00, 0, 0, 0);
    add(0, 8'h02, 0, 0, 1, 8'h02, 1, 0, 0);
    add(0, 8'h02, 1, 0, 0, 8'h02, 1, 1, 1);
    add(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1);

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      req_in = tbl[i].req;
      grant_ready = tbl[i].rdy;
      done = tbl[i].dn;
      cyc();
      chk($sformatf("tbl%0d_valid", i), grant_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_oh", i), grant_oh, tbl[i].eoh);
      chk($sformatf("tbl%0d_idx", i), grant_idx, tbl[i].eidx);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("tbl%0d_count", i), grant_count, tbl[i].ecnt);
    end

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      r = $urandom();
      req_in = ($urandom_range(0, 3) == 0) ? 8'h00 : r[7:0];
      grant_ready = ($urandom_range(0, 1) == 1);
      done = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
